// File: rtl/vend_pkg.sv
// Shared types and constants for the vending payment front-end.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CONFIRM,
        CANCEL,
        DONE
    } pay_state_t;

    localparam logic [2:0] COIN1_V = 3'd1;
    localparam logic [2:0] COIN2_V = 3'd2;
    localparam logic [2:0] COIN5_V = 3'd5;
    localparam logic [6:0] PAY_MAX = 7'd99;

    // Running total plus one coin, clamped to the two-digit display range.
    function automatic logic [6:0] sat_add(input logic [6:0] total, input logic [2:0] coin);
        logic [7:0] sum;
        sum = {1'b0, total} + {5'd0, coin};
        return (sum > {1'b0, PAY_MAX}) ? PAY_MAX : sum[6:0];
    endfunction

endpackage

// File: rtl/vend_pay_ctrl_if.sv
// Processor-facing order/strobe/display bundle of the payment front-end.
interface vend_pay_ctrl_if;

    logic       start;
    logic [6:0] due;
    logic [2:0] money;
    logic       enc;
    logic       cancel;
    logic [6:0] paid;
    logic       busy;
    logic [3:0] sec10;
    logic [3:0] sec1;

    // master: the payment controller, which issues the strobes
    modport master (
        input  start, due,
        output money, enc, cancel, paid, busy, sec10, sec1
    );

    // slave: the vending processor consuming the strobes
    modport slave (
        output start, due,
        input  money, enc, cancel, paid, busy, sec10, sec1
    );

endinterface

// File: rtl/vend_pay_ctrl_btn_sync_edge.sv
// Raw button to one-cycle rising-edge pulse: 2-flop synchronizer, optional
// stability filter when VEND_COIN_DEBOUNCE_EN is defined, then edge detect.
module btn_sync_edge #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic sync0_reg;
    logic sync1_reg;
    logic level;
    logic prev_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0_reg <= 1'b0;
            sync1_reg <= 1'b0;
        end else begin
            sync0_reg <= btn;
            sync1_reg <= sync0_reg;
        end
    end

`ifdef VEND_COIN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] stable_cnt_reg;
    logic             level_reg;

    // The accepted level only follows the input after an unbroken run of
    // differing samples; any return to the old level restarts the run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_cnt_reg <= '0;
            level_reg      <= 1'b0;
        end else if (sync1_reg == level_reg) begin
            stable_cnt_reg <= '0;
        end else if (stable_cnt_reg == CNT_LAST) begin
            stable_cnt_reg <= '0;
            level_reg      <= sync1_reg;
        end else begin
            stable_cnt_reg <= stable_cnt_reg + 1'b1;
        end
    end

    assign level = level_reg;
`else
    assign level = sync1_reg;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= level;
        end
    end

    // Combinational so the consumer's registered output lands 3 cycles after the raw edge.
    assign rise = level & ~prev_reg;

endmodule

// File: rtl/vend_pay_ctrl.sv
// Payment front-end: collects coins against the order total inside a timed
// window and issues money/enc/cancel strobes. Debounce via VEND_COIN_DEBOUNCE_EN.
module vend_pay_ctrl
    import vend_pkg::*;
#(
    parameter int TICKS_PER_SEC   = 100_000_000,
    parameter int TIMEOUT_S       = 30,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            coin1,
    input  logic            coin2,
    input  logic            coin5,
    input  logic            abort,
    vend_pay_ctrl_if.master pif
);

    localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [3:0] SEC10_INIT = 4'(TIMEOUT_S / 10);
    localparam logic [3:0] SEC1_INIT  = 4'(TIMEOUT_S % 10);

    // Button index order: 0 coin1, 1 coin2, 2 coin5, 3 abort.
    logic [3:0] btn_raw;
    logic [3:0] btn_rise;

    assign btn_raw = {abort, coin5, coin2, coin1};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            btn_sync_edge #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_btn (
                .clk  (clk),
                .reset(reset),
                .btn  (btn_raw[gi]),
                .rise (btn_rise[gi])
            );
        end
    endgenerate

    pay_state_t        state_reg, state_next;
    logic [6:0]        due_reg, due_next;
    logic [6:0]        paid_reg, paid_next;
    logic [TICK_W-1:0] tick_reg, tick_next;
    logic [3:0]        sec10_reg, sec10_next;
    logic [3:0]        sec1_reg, sec1_next;
    logic [2:0]        money_reg, money_next;
    logic              enc_reg, enc_next;
    logic              cancel_reg, cancel_next;
    logic              busy_reg, busy_next;
    logic              start_prev_reg;

    logic              start_rise;
    logic [2:0]        coin_v;
    logic [6:0]        paid_sum;
    logic              tick_wrap;
    logic              expire;

    assign start_rise = pif.start & ~start_prev_reg;
    assign paid_sum   = sat_add(paid_reg, coin_v);
    assign tick_wrap  = (tick_reg == TICK_LAST);
    assign expire     = tick_wrap && (sec10_reg == 4'd0) && (sec1_reg == 4'd1);

    always_comb begin
        coin_v = '0;
        if (btn_rise[2]) begin
            coin_v = COIN5_V;
        end else if (btn_rise[1]) begin
            coin_v = COIN2_V;
        end else if (btn_rise[0]) begin
            coin_v = COIN1_V;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            due_reg        <= '0;
            paid_reg       <= '0;
            tick_reg       <= '0;
            sec10_reg      <= '0;
            sec1_reg       <= '0;
            money_reg      <= '0;
            enc_reg        <= 1'b0;
            cancel_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            start_prev_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            due_reg        <= due_next;
            paid_reg       <= paid_next;
            tick_reg       <= tick_next;
            sec10_reg      <= sec10_next;
            sec1_reg       <= sec1_next;
            money_reg      <= money_next;
            enc_reg        <= enc_next;
            cancel_reg     <= cancel_next;
            busy_reg       <= busy_next;
            start_prev_reg <= pif.start;
        end
    end

    always_comb begin
        state_next  = state_reg;
        due_next    = due_reg;
        paid_next   = paid_reg;
        tick_next   = tick_reg;
        sec10_next  = sec10_reg;
        sec1_next   = sec1_reg;
        money_next  = '0;
        enc_next    = 1'b0;
        cancel_next = 1'b0;

        case (state_reg)
            IDLE: begin
                paid_next  = '0;
                sec10_next = '0;
                sec1_next  = '0;
                if (start_rise) begin
                    due_next   = pif.due;
                    sec10_next = SEC10_INIT;
                    sec1_next  = SEC1_INIT;
                    tick_next  = '0;
                    state_next = (pif.due == 7'd0) ? CONFIRM : COLLECT;
                end
            end

            COLLECT: begin
                if (tick_wrap) begin
                    tick_next = '0;
                    if (sec1_reg == 4'd0) begin
                        sec1_next  = 4'd9;
                        sec10_next = sec10_reg - 4'd1;
                    end else begin
                        sec1_next = sec1_reg - 4'd1;
                    end
                end else begin
                    tick_next = tick_reg + 1'b1;
                end

                // abort wins over any coin; a completing coin wins over expiry
                if (btn_rise[3]) begin
                    state_next = CANCEL;
                end else begin
                    if (coin_v != 3'd0) begin
                        money_next = coin_v;
                        paid_next  = paid_sum;
                    end
                    if ((coin_v != 3'd0) && (paid_sum >= due_reg)) begin
                        state_next = CONFIRM;
                    end else if (expire) begin
                        state_next = CANCEL;
                    end
                end
            end

            CONFIRM: begin
                enc_next   = 1'b1;
                state_next = DONE;
            end

            CANCEL: begin
                cancel_next = 1'b1;
                state_next  = DONE;
            end

            DONE: begin
                if (!pif.start) begin
                    state_next = IDLE;
                    paid_next  = '0;
                    sec10_next = '0;
                    sec1_next  = '0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy_next = (state_next == COLLECT) || (state_next == DONE);

    assign pif.money  = money_reg;
    assign pif.enc    = enc_reg;
    assign pif.cancel = cancel_reg;
    assign pif.paid   = paid_reg;
    assign pif.busy   = busy_reg;
    assign pif.sec10  = sec10_reg;
    assign pif.sec1   = sec1_reg;

endmodule

// File: tb/tb_vend_pay_ctrl.sv
// Scoreboard bench for vend_pay_ctrl with TICKS_PER_SEC=4, TIMEOUT_S=30.
// Define VEND_COIN_DEBOUNCE_EN to run the filter scenario instead of the main set.
module tb_vend_pay_ctrl;

    localparam int EV_ENC    = 10;
    localparam int EV_CANCEL = 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic coin1 = 1'b0;
    logic coin2 = 1'b0;
    logic coin5 = 1'b0;
    logic abort = 1'b0;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int obs_q[$];

    vend_pay_ctrl_if bus ();

    vend_pay_ctrl #(
        .TICKS_PER_SEC  (4),
        .TIMEOUT_S      (30),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .coin1(coin1),
        .coin2(coin2),
        .coin5(coin5),
        .abort(abort),
        .pif  (bus)
    );

    always #5 clk = ~clk;

    // Monitor: every strobe the DUT emits becomes one observed event.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.money != 3'd0) obs_q.push_back(int'(bus.money));
            if (bus.enc)           obs_q.push_back(EV_ENC);
            if (bus.cancel)        obs_q.push_back(EV_CANCEL);
        end
    end

    task automatic press(input logic c1, input logic c2, input logic c5, input logic ab);
        coin1 = c1; coin2 = c2; coin5 = c5; abort = ab;
        @(negedge clk);
        coin1 = 1'b0; coin2 = 1'b0; coin5 = 1'b0; abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic begin_order(input int d);
        bus.due   = 7'(d);
        bus.start = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_order;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        checks++;
        if ({bus.money, bus.enc, bus.cancel, bus.paid, bus.busy, bus.sec10, bus.sec1} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h expected=0",
                     {bus.money, bus.enc, bus.cancel, bus.paid, bus.busy, bus.sec10, bus.sec1});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.money, bus.enc, bus.cancel, bus.paid, bus.busy, bus.sec10, bus.sec1} !== 21'd0) begin
            failures++;
            $display("FAIL idle_outputs got=%h expected=0",
                     {bus.money, bus.enc, bus.cancel, bus.paid, bus.busy, bus.sec10, bus.sec1});
        end
        $display("txn reset done");
    endtask

    task automatic test_exact_pay;
        int e, o;
        begin_order(7);
        checks++;
        if ({bus.busy, bus.sec10, bus.sec1} !== {1'b1, 4'd3, 4'd0}) begin
            failures++;
            $display("FAIL exact_entry got=%h expected=130", {bus.busy, bus.sec10, bus.sec1});
        end
        press(1'b0, 1'b0, 1'b1, 1'b0); exp_q.push_back(5);
        press(1'b0, 1'b1, 1'b0, 1'b0); exp_q.push_back(2); exp_q.push_back(EV_ENC);
        repeat (4) @(negedge clk);
        press(1'b1, 1'b0, 1'b0, 1'b0);  // in DONE: must be ignored
        repeat (4) @(negedge clk);
        checks++;
        if (bus.paid !== 7'd7) begin
            failures++;
            $display("FAIL exact_paid got=%0d expected=7", bus.paid);
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL exact_busy_done got=%b expected=1", bus.busy);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = -1;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL exact_event got=%0d expected=%0d", o, e);
            end else $display("txn exact_pay event=%0d", o);
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL exact_extra got=%0d extra events expected=0", obs_q.size());
            obs_q.delete();
        end
        end_order();
        checks++;
        if ({bus.busy, bus.paid} !== 8'd0) begin
            failures++;
            $display("FAIL exact_busy_fall got=%h expected=0", {bus.busy, bus.paid});
        end
    endtask

    task automatic test_overpay_saturate;
        int e, o;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                begin_order(3);
                press(1'b0, 1'b0, 1'b1, 1'b0); exp_q.push_back(5);
            end else begin
                begin_order(99);
                for (int k = 0; k < 20; k++) begin
                    press(1'b0, 1'b0, 1'b1, 1'b0); exp_q.push_back(5);
                end
            end
            exp_q.push_back(EV_ENC);
            repeat (6) @(negedge clk);
            checks++;
            if (bus.paid !== ((i == 0) ? 7'd5 : 7'd99)) begin
                failures++;
                $display("FAIL overpay_paid case=%0d got=%0d expected=%0d", i, bus.paid, (i == 0) ? 5 : 99);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = -1;
                if (obs_q.size() > 0) o = obs_q.pop_front();
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL overpay_event case=%0d got=%0d expected=%0d", i, o, e);
                end else $display("txn overpay case=%0d event=%0d", i, o);
            end
            checks++;
            if (obs_q.size() != 0) begin
                failures++;
                $display("FAIL overpay_extra case=%0d got=%0d extra events expected=0", i, obs_q.size());
                obs_q.delete();
            end
            end_order();
        end
    endtask

    task automatic test_timeout;
        int e, o, rem;
        logic [7:0] exp_bcd;
        bus.due   = 7'd9;
        bus.start = 1'b1;
        // Negedge m follows entry by m-1 cycles; one second per 4 cycles.
        for (int m = 1; m <= 121; m++) begin
            @(negedge clk);
            if (m == 5) begin coin2 = 1'b1; exp_q.push_back(2); end
            if (m == 6) coin2 = 1'b0;
            rem     = 30 - (m - 1) / 4;
            exp_bcd = {4'(rem / 10), 4'(rem % 10)};
            checks++;
            if ({bus.sec10, bus.sec1} !== exp_bcd) begin
                failures++;
                $display("FAIL timeout_secs cycle=%0d got=%h expected=%h", m, {bus.sec10, bus.sec1}, exp_bcd);
            end
        end
        exp_q.push_back(EV_CANCEL);
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.paid, bus.sec10, bus.sec1} !== {1'b1, 7'd2, 8'h00}) begin
            failures++;
            $display("FAIL timeout_hold got=%h expected=%h", {bus.busy, bus.paid, bus.sec10, bus.sec1},
                     {1'b1, 7'd2, 8'h00});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = -1;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL timeout_event got=%0d expected=%0d", o, e);
            end else $display("txn timeout event=%0d", o);
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL timeout_extra got=%0d extra events expected=0", obs_q.size());
            obs_q.delete();
        end
        end_order();
    endtask

    task automatic test_timeout_race;
        int e, o;
        for (int i = 0; i < 2; i++) begin
            bus.due   = (i == 0) ? 7'd5 : 7'd9;
            bus.start = 1'b1;
            // Raw edge set here reaches the FSM exactly on the 01->00 cycle.
            repeat (118) @(negedge clk);
            if (i == 0) begin coin5 = 1'b1; exp_q.push_back(5); end
            else        begin coin2 = 1'b1; exp_q.push_back(2); end
            @(negedge clk);
            coin5 = 1'b0; coin2 = 1'b0;
            repeat (4) @(negedge clk);
            exp_q.push_back((i == 0) ? EV_ENC : EV_CANCEL);
            checks++;
            if (bus.paid !== ((i == 0) ? 7'd5 : 7'd2)) begin
                failures++;
                $display("FAIL race_paid case=%0d got=%0d expected=%0d", i, bus.paid, (i == 0) ? 5 : 2);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = -1;
                if (obs_q.size() > 0) o = obs_q.pop_front();
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL race_event case=%0d got=%0d expected=%0d", i, o, e);
                end else $display("txn race case=%0d event=%0d", i, o);
            end
            checks++;
            if (obs_q.size() != 0) begin
                failures++;
                $display("FAIL race_extra case=%0d got=%0d extra events expected=0", i, obs_q.size());
                obs_q.delete();
            end
            end_order();
        end
    endtask

    task automatic test_simultaneous;
        int e, o;
        for (int i = 0; i < 2; i++) begin
            begin_order(9);
            if (i == 0) begin
                press(1'b1, 1'b0, 1'b1, 1'b0); exp_q.push_back(5);
                press(1'b0, 1'b0, 1'b0, 1'b1);
            end else begin
                press(1'b1, 1'b0, 1'b0, 1'b0); exp_q.push_back(1);
                press(1'b0, 1'b0, 1'b1, 1'b1);
            end
            exp_q.push_back(EV_CANCEL);
            repeat (5) @(negedge clk);
            checks++;
            if (bus.paid !== ((i == 0) ? 7'd5 : 7'd1)) begin
                failures++;
                $display("FAIL simul_paid case=%0d got=%0d expected=%0d", i, bus.paid, (i == 0) ? 5 : 1);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = -1;
                if (obs_q.size() > 0) o = obs_q.pop_front();
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL simul_event case=%0d got=%0d expected=%0d", i, o, e);
                end else $display("txn simul case=%0d event=%0d", i, o);
            end
            checks++;
            if (obs_q.size() != 0) begin
                failures++;
                $display("FAIL simul_extra case=%0d got=%0d extra events expected=0", i, obs_q.size());
                obs_q.delete();
            end
            end_order();
        end
    endtask

    task automatic test_reset_mid;
        int e, o;
        begin_order(9);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (bus.paid !== 7'd4) begin
            failures++;
            $display("FAIL rstmid_paid_before got=%0d expected=4", bus.paid);
        end
        obs_q.delete();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.money, bus.enc, bus.cancel, bus.paid, bus.busy, bus.sec10, bus.sec1} !== 21'd0) begin
            failures++;
            $display("FAIL rstmid_async got=%h expected=0",
                     {bus.money, bus.enc, bus.cancel, bus.paid, bus.busy, bus.sec10, bus.sec1});
        end
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_pulses got=%0d events expected=0", obs_q.size());
            obs_q.delete();
        end
        begin_order(2);
        press(1'b0, 1'b1, 1'b0, 1'b0); exp_q.push_back(2); exp_q.push_back(EV_ENC);
        repeat (5) @(negedge clk);
        checks++;
        if (bus.paid !== 7'd2) begin
            failures++;
            $display("FAIL rstmid_new_paid got=%0d expected=2", bus.paid);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = -1;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rstmid_event got=%0d expected=%0d", o, e);
            end else $display("txn reset_mid new_order event=%0d", o);
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_extra got=%0d extra events expected=0", obs_q.size());
            obs_q.delete();
        end
        end_order();
    endtask

    // Long press / glitch handling: without the filter a held button is one
    // edge; with it a short glitch is rejected and a long press counts once.
    task automatic test_button_filter;
        int e, o;
        begin_order(9);
`ifdef VEND_COIN_DEBOUNCE_EN
        coin2 = 1'b1; repeat (5) @(negedge clk);
        coin2 = 1'b0; repeat (15) @(negedge clk);
`endif
        coin2 = 1'b1; repeat (12) @(negedge clk);
        coin2 = 1'b0; repeat (20) @(negedge clk);
        exp_q.push_back(2);
        abort = 1'b1; repeat (12) @(negedge clk);
        abort = 1'b0; repeat (20) @(negedge clk);
        exp_q.push_back(EV_CANCEL);
        checks++;
        if (bus.paid !== 7'd2) begin
            failures++;
            $display("FAIL filter_paid got=%0d expected=2", bus.paid);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = -1;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL filter_event got=%0d expected=%0d", o, e);
            end else $display("txn filter event=%0d", o);
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL filter_extra got=%0d extra events expected=0", obs_q.size());
            obs_q.delete();
        end
        end_order();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.due   = 7'd0;
        repeat (3) @(negedge clk);
        test_reset();
`ifndef VEND_COIN_DEBOUNCE_EN
        test_exact_pay();
        test_overpay_saturate();
        test_timeout();
        test_timeout_race();
        test_simultaneous();
        test_reset_mid();
`endif
        test_button_filter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
